pilha_operandos: RTL and testbench

PILHA_OPERANDOS -- requirements
Module: pilha_operandos

---
 rtl/pilha_operandos.sv | 176 +++++++++++++++++
 tb/tb_pilha_operandos.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pilha_operandos.sv
// Operand stack with result register and exec edge detection for a switch-driven calculator datapath.
// Optional result flags are built when ULA_FLAGS_EN is defined; otherwise the flag ports read 0.
module pilha_operandos #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [LARGURA-1:0]                dado_in,
    input  logic [LARGURA-1:0]                ula_res,
    input  logic                              ula_carry,
    input  logic                              habilitaA,
    input  logic                              habilitaB,
    input  logic                              habilitaOp,
    input  logic                              habilitaExec,
    input  logic                              selMuxA,
    input  logic                              resetFSM,
    output logic [LARGURA-1:0]                opA,
    output logic [LARGURA-1:0]                opB,
    output logic [2:0]                        op,
    output logic [LARGURA-1:0]                resReg,
    output logic                              pode_avancar,
    output logic [$clog2(PROFUNDIDADE):0]     ocupacao,
    output logic                              vazia,
    output logic                              cheia,
    output logic                              exec_valido,
    output logic                              erro,
    output logic                              flag_zero,
    output logic                              flag_neg,
    output logic                              flag_carry
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] CAPACIDADE = OW'(PROFUNDIDADE);

    logic [LARGURA-1:0] pilha_q [PROFUNDIDADE];
    logic [LARGURA-1:0] pilha_d [PROFUNDIDADE];
    logic [OW-1:0]      ocup_q, ocup_d;
    logic [2:0]         op_q, op_d;
    logic [LARGURA-1:0] res_q, res_d;
    logic               erro_q, erro_d;
    logic               exec_valido_q, exec_valido_d;
    logic               exec_prev_q, exec_prev_d;

    logic               exec_borda;
    logic               empilha;
    logic               captura;
    logic [LARGURA-1:0] dado_empilha;
    logic [OW-1:0]      idx_topo;
    logic [OW-1:0]      idx_segundo;

    assign exec_borda   = habilitaExec & ~exec_prev_q;
    assign empilha      = habilitaA | habilitaB;
    assign dado_empilha = selMuxA ? res_q : dado_in;

    assign vazia        = (ocup_q == '0);
    assign cheia        = (ocup_q == CAPACIDADE);
    assign pode_avancar = (ocup_q >= OW'(2));

    assign idx_topo    = ocup_q - OW'(1);
    assign idx_segundo = ocup_q - OW'(2);

    // Unoccupied positions read as zero rather than stale stack contents.
    assign opB = vazia        ? '0 : pilha_q[idx_topo[PW-1:0]];
    assign opA = pode_avancar ? pilha_q[idx_segundo[PW-1:0]] : '0;

    assign op          = op_q;
    assign resReg      = res_q;
    assign ocupacao    = ocup_q;
    assign erro        = erro_q;
    assign exec_valido = exec_valido_q;

    // Priority: resetFSM, then exec edge, then push; opcode load rides along with push only.
    always_comb begin
        pilha_d       = pilha_q;
        ocup_d        = ocup_q;
        op_d          = op_q;
        res_d         = res_q;
        erro_d        = erro_q;
        exec_valido_d = 1'b0;
        exec_prev_d   = habilitaExec;
        captura       = 1'b0;

        if (resetFSM) begin
            ocup_d = '0;
            op_d   = '0;
        end else if (exec_borda) begin
            if (pode_avancar) begin
                res_d         = ula_res;
                ocup_d        = ocup_q - OW'(2);
                exec_valido_d = 1'b1;
                captura       = 1'b1;
            end else begin
                erro_d = 1'b1;
            end
        end else begin
            if (empilha) begin
                if (cheia) begin
                    erro_d = 1'b1;
                end else begin
                    pilha_d[ocup_q[PW-1:0]] = dado_empilha;
                    ocup_d                  = ocup_q + OW'(1);
                end
            end
            if (habilitaOp) begin
                op_d = dado_in[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                pilha_q[i] <= '0;
            end
            ocup_q        <= '0;
            op_q          <= '0;
            res_q         <= '0;
            erro_q        <= 1'b0;
            exec_valido_q <= 1'b0;
            exec_prev_q   <= 1'b0;
        end else begin
            pilha_q       <= pilha_d;
            ocup_q        <= ocup_d;
            op_q          <= op_d;
            res_q         <= res_d;
            erro_q        <= erro_d;
            exec_valido_q <= exec_valido_d;
            exec_prev_q   <= exec_prev_d;
        end
    end

`ifdef ULA_FLAGS_EN
    logic flag_zero_q, flag_zero_d;
    logic flag_neg_q, flag_neg_d;
    logic flag_carry_q, flag_carry_d;

    always_comb begin
        flag_zero_d  = flag_zero_q;
        flag_neg_d   = flag_neg_q;
        flag_carry_d = flag_carry_q;
        if (captura) begin
            flag_zero_d  = (ula_res == '0);
            flag_neg_d   = ula_res[LARGURA-1];
            flag_carry_d = ula_carry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_zero_q  <= 1'b0;
            flag_neg_q   <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            flag_zero_q  <= flag_zero_d;
            flag_neg_q   <= flag_neg_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign flag_zero  = flag_zero_q;
    assign flag_neg   = flag_neg_q;
    assign flag_carry = flag_carry_q;
`else
    logic captura_nao_usada;
    logic carry_nao_usado;

    assign captura_nao_usada = captura;
    assign carry_nao_usado   = ula_carry;
    assign flag_zero  = 1'b0;
    assign flag_neg   = 1'b0;
    assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_pilha_operandos.sv
// Scoreboard bench for pilha_operandos: a queue-based reference model predicts every cycle's outputs.
module tb_pilha_operandos;

    localparam int L = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [L-1:0] dado_in = '0;
    logic [L-1:0] ula_res = '0;
    logic         ula_carry = 1'b0;
    logic         habilitaA = 1'b0, habilitaB = 1'b0, habilitaOp = 1'b0;
    logic         habilitaExec = 1'b0, selMuxA = 1'b0, resetFSM = 1'b0;
    logic [L-1:0] opA, opB, resReg;
    logic [2:0]   op;
    logic         pode_avancar, vazia, cheia, exec_valido, erro;
    logic [2:0]   ocupacao;
    logic         flag_zero, flag_neg, flag_carry;

    pilha_operandos #(.LARGURA(L), .PROFUNDIDADE(P)) dut (
        .clk(clk), .rst(rst), .dado_in(dado_in), .ula_res(ula_res), .ula_carry(ula_carry),
        .habilitaA(habilitaA), .habilitaB(habilitaB), .habilitaOp(habilitaOp),
        .habilitaExec(habilitaExec), .selMuxA(selMuxA), .resetFSM(resetFSM),
        .opA(opA), .opB(opB), .op(op), .resReg(resReg), .pode_avancar(pode_avancar),
        .ocupacao(ocupacao), .vazia(vazia), .cheia(cheia), .exec_valido(exec_valido),
        .erro(erro), .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0] opA, opB, res;
        logic [2:0]   op, ocup;
        logic         vazia, cheia, pode, ev, erro, fz, fn, fc;
    } exp_t;

    exp_t         exp_q[$];
    logic [L-1:0] res_fila[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [L-1:0] m_stk[$];
    logic [2:0]   m_op = '0;
    logic [L-1:0] m_res = '0;
    logic         m_erro = 1'b0, m_prev = 1'b0, m_fz = 1'b0, m_fn = 1'b0, m_fc = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_op = '0; m_res = '0; m_erro = 1'b0; m_prev = 1'b0;
        m_fz = 1'b0; m_fn = 1'b0; m_fc = 1'b0;
    endtask

    task automatic drive(input logic a, input logic b, input logic o, input logic x,
                         input logic s, input logic r, input logic [L-1:0] d,
                         input logic [L-1:0] u, input logic c);
        exp_t e;
        logic borda;
        logic ev;
        @(negedge clk);
        habilitaA = a; habilitaB = b; habilitaOp = o; habilitaExec = x;
        selMuxA = s; resetFSM = r; dado_in = d; ula_res = u; ula_carry = c;

        borda = x && !m_prev;
        m_prev = x;
        ev = 1'b0;
        if (r) begin
            m_stk.delete();
            m_op = '0;
        end else if (borda) begin
            if (m_stk.size() >= 2) begin
                m_res = u;
                void'(m_stk.pop_back());
                void'(m_stk.pop_back());
                ev = 1'b1;
`ifdef ULA_FLAGS_EN
                m_fz = (u == '0);
                m_fn = u[L-1];
                m_fc = c;
`endif
                res_fila.push_back(u);
            end else begin
                m_erro = 1'b1;
            end
        end else begin
            if (a || b) begin
                if (m_stk.size() == P) m_erro = 1'b1;
                else m_stk.push_back(s ? m_res : d);
            end
            if (o) m_op = d[2:0];
        end

        e.ocup  = 3'(m_stk.size());
        e.opB   = (m_stk.size() >= 1) ? m_stk[m_stk.size()-1] : '0;
        e.opA   = (m_stk.size() >= 2) ? m_stk[m_stk.size()-2] : '0;
        e.vazia = (m_stk.size() == 0);
        e.cheia = (m_stk.size() == P);
        e.pode  = (m_stk.size() >= 2);
        e.op    = m_op;
        e.res   = m_res;
        e.ev    = ev;
        e.erro  = m_erro;
        e.fz    = m_fz;
        e.fn    = m_fn;
        e.fc    = m_fc;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every predicted cycle and every captured result independently.
    initial begin : monitor
        exp_t e;
        logic [L-1:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (exec_valido === 1'b1) begin
                if (res_fila.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL exec_valido_spurious: got 1, expected 0 (t=%0t)", $time);
                end else begin
                    r = res_fila.pop_front();
                    check("resReg_capture", 32'(resReg), 32'(r));
                end
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("opA", 32'(opA), 32'(e.opA));
                check("opB", 32'(opB), 32'(e.opB));
                check("ocupacao", 32'(ocupacao), 32'(e.ocup));
                check("vazia", 32'(vazia), 32'(e.vazia));
                check("cheia", 32'(cheia), 32'(e.cheia));
                check("pode_avancar", 32'(pode_avancar), 32'(e.pode));
                check("op", 32'(op), 32'(e.op));
                check("resReg", 32'(resReg), 32'(e.res));
                check("exec_valido", 32'(exec_valido), 32'(e.ev));
                check("erro", 32'(erro), 32'(e.erro));
                check("flag_zero", 32'(flag_zero), 32'(e.fz));
                check("flag_neg", 32'(flag_neg), 32'(e.fn));
                check("flag_carry", 32'(flag_carry), 32'(e.fc));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ocupacao"}, 32'(ocupacao), 32'd0);
        check({tag, "_opA"}, 32'(opA), 32'd0);
        check({tag, "_opB"}, 32'(opB), 32'd0);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_resReg"}, 32'(resReg), 32'd0);
        check({tag, "_erro"}, 32'(erro), 32'd0);
        check({tag, "_exec_valido"}, 32'(exec_valido), 32'd0);
        check({tag, "_vazia"}, 32'(vazia), 32'd1);
        check({tag, "_flags"}, 32'({flag_zero, flag_neg, flag_carry}), 32'd0);
    endtask

    initial begin : stimulus
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Two pushes, then exec held high for several cycles
        drive(1, 0, 0, 0, 0, 0, 8'h05, '0, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h03, '0, 0);
        idle();
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, '0, 8'h08, 0);
        idle();
        // Reuse result, then soft reset keeps resReg
        drive(1, 0, 0, 0, 1, 0, 8'h55, '0, 0);
        drive(0, 0, 0, 0, 0, 1, '0, '0, 0);
        idle();
        // Overflow: five pushes, also an opcode load alongside a push
        for (int i = 1; i <= 5; i++) drive(1, 0, (i == 2), 0, 0, 0, 8'(i), '0, 0);
        idle();
        // Soft reset beats push in the same cycle
        drive(1, 0, 1, 0, 0, 1, 8'h09, '0, 0);
        idle();
        // Flag cases: negative with carry, then zero
        drive(1, 0, 0, 0, 0, 0, 8'h40, '0, 0);
        drive(0, 1, 0, 0, 0, 0, 8'h40, '0, 0);
        drive(0, 0, 0, 1, 0, 0, '0, 8'h80, 1);
        idle();
        drive(1, 0, 0, 0, 0, 0, 8'h11, '0, 0);
        drive(1, 0, 0, 0, 0, 0, 8'hEF, '0, 0);
        drive(0, 0, 0, 1, 0, 0, '0, 8'h00, 1);
        idle();
        // Underflow exec
        drive(0, 0, 0, 1, 0, 0, '0, 8'h77, 0);
        idle();

        for (int i = 0; i < 500; i++) begin
            logic [L-1:0] u;
            u = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  8'($urandom), u, 1'($urandom));
        end
        idle();
        drain();

        // Asynchronous reset in the middle of an exec pulse
        drive(1, 0, 0, 0, 0, 0, 8'hA1, '0, 0);
        drive(1, 0, 0, 0, 0, 0, 8'hB2, '0, 0);
        idle();
        drain();
        habilitaExec = 1'b1;
        ula_res = 8'h3C;
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        habilitaExec = 1'b0;
        @(negedge clk);
        check_all_zero("reset_held");
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 100; i++) begin
            drive(($urandom_range(0, 1) == 0), 1'b0, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        idle();
        drain();
        check("result_queue_drained", 32'(res_fila.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
